// File: rtl/rbm_compute_seq.sv
// RBM compute sequencer: walks users through read-DMA, train/predict and
// write-DMA steps, with a single advance enable (step) gating every change.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for conf_done; latches configuration (codes 8-15 alias here)
// RD_REQ  | read DMA request raised, waiting for rd_grant
// RD_WAIT | read granted, waiting for rd_complete
// TRAIN   | compute engine training current user
// PREDICT | compute engine predicting current user
// WR_REQ  | write DMA request raised, waiting for wr_grant
// WR_WAIT | write granted, waiting for wr_complete
// DONE    | all work finished; held until conf_done drops
module rbm_compute_seq #(
  parameter int IDX_W     = 16,
  parameter int ADDR_W    = 32,
  parameter int K_RATINGS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              conf_done,
  input  logic [31:0]       conf_num_movies,
  input  logic [31:0]       conf_num_users,
  input  logic [31:0]       conf_num_testusers,
  input  logic [31:0]       conf_num_loops,
  input  logic [31:0]       conf_num_hidden,
  input  logic [31:0]       conf_num_visible,
  input  logic              rd_grant,
  input  logic              rd_complete,
  input  logic              wr_grant,
  input  logic              wr_complete,
  input  logic              train_done,
  input  logic              predict_done,
  output logic              rd_request,
  output logic [ADDR_W-1:0] rd_index,
  output logic [ADDR_W-1:0] rd_length,
  output logic              wr_request,
  output logic [ADDR_W-1:0] wr_index,
  output logic [ADDR_W-1:0] wr_length,
  output logic              train_start,
  output logic              predict_start,
  output logic [IDX_W-1:0]  num_movies,
  output logic [IDX_W-1:0]  num_users,
  output logic [IDX_W-1:0]  num_testusers,
  output logic [IDX_W-1:0]  num_loops,
  output logic [IDX_W-1:0]  num_hidden,
  output logic [IDX_W-1:0]  num_visible,
  output logic [IDX_W-1:0]  loop_count,
  output logic [IDX_W-1:0]  user_index,
  output logic [3:0]        upc,
  output logic              init_done,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD_REQ  = 4'd1,
    S_RD_WAIT = 4'd2,
    S_TRAIN   = 4'd3,
    S_PREDICT = 4'd4,
    S_WR_REQ  = 4'd5,
    S_WR_WAIT = 4'd6,
    S_DONE    = 4'd7
  } state_t;

  state_t state, state_nxt;

  logic              phase_train, phase_train_nxt;
  logic              init_done_nxt, train_start_nxt, predict_start_nxt;
  logic [IDX_W-1:0]  movies_nxt, users_nxt, testusers_nxt, loops_nxt, hidden_nxt, visible_nxt;
  logic [IDX_W-1:0]  loop_nxt, user_nxt;
  logic [ADDR_W-1:0] rd_index_nxt, rd_length_nxt, wr_index_nxt, wr_length_nxt;

  logic [IDX_W-1:0]  conf_movies_t, conf_users_t, conf_test_t, conf_loops_t;
  logic [IDX_W-1:0]  user_inc, loop_inc;
  logic [ADDR_W-1:0] len_conf;
  logic              rd_done_now, wr_done_now;

  // index = user * length, wrapping at the DMA field width
  function automatic logic [ADDR_W-1:0] idx_mul(input logic [IDX_W-1:0] u,
                                                input logic [ADDR_W-1:0] len);
    return ADDR_W'(u) * len;
  endfunction

  assign conf_movies_t = conf_num_movies[IDX_W-1:0];
  assign conf_users_t  = conf_num_users[IDX_W-1:0];
  assign conf_test_t   = conf_num_testusers[IDX_W-1:0];
  assign conf_loops_t  = conf_num_loops[IDX_W-1:0];
  assign len_conf      = ADDR_W'(K_RATINGS) * ADDR_W'(conf_movies_t);
  assign user_inc      = user_index + IDX_W'(1);
  assign loop_inc      = loop_count + IDX_W'(1);

  // Configuration bits above IDX_W are intentionally discarded.
  if (IDX_W < 32) begin : g_conf_hi
    logic unused_conf_hi;
    assign unused_conf_hi = ^{conf_num_movies[31:IDX_W], conf_num_users[31:IDX_W],
                              conf_num_testusers[31:IDX_W], conf_num_loops[31:IDX_W],
                              conf_num_hidden[31:IDX_W], conf_num_visible[31:IDX_W]};
  end

  // A transfer finishes either in the wait state or together with its grant.
  assign rd_done_now = ((state == S_RD_REQ) && rd_grant && rd_complete) ||
                       ((state == S_RD_WAIT) && rd_complete);
  assign wr_done_now = ((state == S_WR_REQ) && wr_grant && wr_complete) ||
                       ((state == S_WR_WAIT) && wr_complete);

  assign upc        = state;
  assign rd_request = (state == S_RD_REQ);
  assign wr_request = (state == S_WR_REQ);
  assign done       = (state == S_DONE);

  // Next-state and next-datapath values; registered only on step.
  always_comb begin
    state_nxt         = state;
    phase_train_nxt   = phase_train;
    init_done_nxt     = init_done;
    train_start_nxt   = 1'b0;
    predict_start_nxt = 1'b0;
    movies_nxt        = num_movies;
    users_nxt         = num_users;
    testusers_nxt     = num_testusers;
    loops_nxt         = num_loops;
    hidden_nxt        = num_hidden;
    visible_nxt       = num_visible;
    loop_nxt          = loop_count;
    user_nxt          = user_index;
    rd_index_nxt      = rd_index;
    rd_length_nxt     = rd_length;
    wr_index_nxt      = wr_index;
    wr_length_nxt     = wr_length;

    case (state)
      S_RD_REQ:
        if (rd_grant && !rd_complete) state_nxt = S_RD_WAIT;
      S_WR_REQ:
        if (wr_grant && !wr_complete) state_nxt = S_WR_WAIT;
      S_RD_WAIT, S_WR_WAIT: ;
      S_TRAIN:
        if (train_done) begin
          if (user_index == num_users - IDX_W'(1)) begin
            user_nxt = '0;
            loop_nxt = loop_inc;
            if (loop_inc == num_loops) begin
              phase_train_nxt = 1'b0;
              if (num_testusers != '0) begin
                state_nxt    = S_RD_REQ;
                rd_index_nxt = '0;
              end else begin
                state_nxt = S_DONE;
              end
            end else begin
              state_nxt    = S_RD_REQ;
              rd_index_nxt = '0;
            end
          end else begin
            user_nxt     = user_inc;
            state_nxt    = S_RD_REQ;
            rd_index_nxt = idx_mul(user_inc, rd_length);
          end
        end
      S_PREDICT:
        if (predict_done) begin
          state_nxt     = S_WR_REQ;
          wr_length_nxt = rd_length;
          wr_index_nxt  = idx_mul(user_index, rd_length);
        end
      S_DONE:
        if (!conf_done) begin
          state_nxt     = S_IDLE;
          init_done_nxt = 1'b0;
        end
      default:
        if (conf_done) begin
          movies_nxt    = conf_movies_t;
          users_nxt     = conf_users_t;
          testusers_nxt = conf_test_t;
          loops_nxt     = conf_loops_t;
          hidden_nxt    = conf_num_hidden[IDX_W-1:0];
          visible_nxt   = conf_num_visible[IDX_W-1:0];
          init_done_nxt = 1'b1;
          loop_nxt      = '0;
          user_nxt      = '0;
          if ((conf_loops_t != '0) && (conf_users_t != '0)) begin
            phase_train_nxt = 1'b1;
            state_nxt       = S_RD_REQ;
            rd_length_nxt   = len_conf;
            rd_index_nxt    = '0;
          end else if (conf_test_t != '0) begin
            phase_train_nxt = 1'b0;
            state_nxt       = S_RD_REQ;
            rd_length_nxt   = len_conf;
            rd_index_nxt    = '0;
          end else begin
            state_nxt = S_DONE;
          end
        end
    endcase

    if (rd_done_now) begin
      if (phase_train) begin
        state_nxt       = S_TRAIN;
        train_start_nxt = 1'b1;
      end else begin
        state_nxt         = S_PREDICT;
        predict_start_nxt = 1'b1;
      end
    end

    if (wr_done_now) begin
      user_nxt = user_inc;
      if (user_index == num_testusers - IDX_W'(1)) begin
        state_nxt = S_DONE;
      end else begin
        state_nxt    = S_RD_REQ;
        rd_index_nxt = idx_mul(user_inc, rd_length);
      end
    end
  end

  // State and datapath registers; frozen while step is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      phase_train   <= 1'b0;
      init_done     <= 1'b0;
      train_start   <= 1'b0;
      predict_start <= 1'b0;
      num_movies    <= '0;
      num_users     <= '0;
      num_testusers <= '0;
      num_loops     <= '0;
      num_hidden    <= '0;
      num_visible   <= '0;
      loop_count    <= '0;
      user_index    <= '0;
      rd_index      <= '0;
      rd_length     <= '0;
      wr_index      <= '0;
      wr_length     <= '0;
    end else if (step) begin
      state         <= state_nxt;
      phase_train   <= phase_train_nxt;
      init_done     <= init_done_nxt;
      train_start   <= train_start_nxt;
      predict_start <= predict_start_nxt;
      num_movies    <= movies_nxt;
      num_users     <= users_nxt;
      num_testusers <= testusers_nxt;
      num_loops     <= loops_nxt;
      num_hidden    <= hidden_nxt;
      num_visible   <= visible_nxt;
      loop_count    <= loop_nxt;
      user_index    <= user_nxt;
      rd_index      <= rd_index_nxt;
      rd_length     <= rd_length_nxt;
      wr_index      <= wr_index_nxt;
      wr_length     <= wr_length_nxt;
    end
  end

endmodule

// File: tb/tb_rbm_compute_seq.sv
// Self-checking bench for rbm_compute_seq: directed corner steps plus
// randomized handshake timing compared against an event-list reference model.
module tb_rbm_compute_seq;

  logic        clk = 1'b0;
  logic        rst, step, conf_done;
  logic [31:0] conf_num_movies, conf_num_users, conf_num_testusers;
  logic [31:0] conf_num_loops, conf_num_hidden, conf_num_visible;
  logic        rd_grant, rd_complete, wr_grant, wr_complete, train_done, predict_done;
  logic        rd_request, wr_request, train_start, predict_start;
  logic [31:0] rd_index, rd_length, wr_index, wr_length;
  logic [15:0] num_movies, num_users, num_testusers, num_loops, num_hidden, num_visible;
  logic [15:0] loop_count, user_index;
  logic [3:0]  upc;
  logic        init_done, done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0]  kind;   // 0 read, 1 write, 2 train start, 3 predict start
    logic [31:0] idx;
    logic [31:0] len;
  } ev_t;

  rbm_compute_seq dut (
    .clk(clk), .rst(rst), .step(step), .conf_done(conf_done),
    .conf_num_movies(conf_num_movies), .conf_num_users(conf_num_users),
    .conf_num_testusers(conf_num_testusers), .conf_num_loops(conf_num_loops),
    .conf_num_hidden(conf_num_hidden), .conf_num_visible(conf_num_visible),
    .rd_grant(rd_grant), .rd_complete(rd_complete),
    .wr_grant(wr_grant), .wr_complete(wr_complete),
    .train_done(train_done), .predict_done(predict_done),
    .rd_request(rd_request), .rd_index(rd_index), .rd_length(rd_length),
    .wr_request(wr_request), .wr_index(wr_index), .wr_length(wr_length),
    .train_start(train_start), .predict_start(predict_start),
    .num_movies(num_movies), .num_users(num_users), .num_testusers(num_testusers),
    .num_loops(num_loops), .num_hidden(num_hidden), .num_visible(num_visible),
    .loop_count(loop_count), .user_index(user_index),
    .upc(upc), .init_done(init_done), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_hs();
    rd_grant = 0; rd_complete = 0; wr_grant = 0; wr_complete = 0;
    train_done = 0; predict_done = 0;
  endtask

  task automatic set_conf(input int mov, input int usr, input int lps, input int tst);
    conf_num_movies    = {16'($urandom), 16'(mov)};
    conf_num_users     = {16'($urandom), 16'(usr)};
    conf_num_loops     = {16'($urandom), 16'(lps)};
    conf_num_testusers = {16'($urandom), 16'(tst)};
    conf_num_hidden    = $urandom;
    conf_num_visible   = $urandom;
  endtask

  // Reference: the ordered list of DMA commands and engine starts a config implies.
  task automatic build_expect(input int mov, input int usr, input int lps, input int tst,
                              output ev_t q[$]);
    logic [31:0] len;
    ev_t e;
    q = {};
    len = 32'(5 * mov);
    if (lps != 0 && usr != 0)
      for (int l = 0; l < lps; l++)
        for (int u = 0; u < usr; u++) begin
          e.kind = 2'd0; e.idx = 32'(u) * len; e.len = len; q.push_back(e);
          e.kind = 2'd2; e.idx = '0; e.len = '0; q.push_back(e);
        end
    for (int u = 0; u < tst; u++) begin
      e.kind = 2'd0; e.idx = 32'(u) * len; e.len = len; q.push_back(e);
      e.kind = 2'd3; e.idx = '0; e.len = '0; q.push_back(e);
      e.kind = 2'd1; e.idx = 32'(u) * len; e.len = len; q.push_back(e);
    end
  endtask

  // Runs one configuration to DONE with random step gaps and handshake delays.
  task automatic run_scenario(input string name, input int mov, input int usr,
                              input int lps, input int tst);
    ev_t exp_q[$];
    ev_t got_q[$];
    ev_t e;
    logic [31:0] hid, vis;
    bit fresh = 0, both_req = 0, got_done = 0, st;
    int rd_cnt = -1, wr_cnt = -1, tr_cnt = -1, pr_cnt = -1, cyc = 0, n;
    build_expect(mov, usr, lps, tst, exp_q);
    set_conf(mov, usr, lps, tst);
    hid = conf_num_hidden;
    vis = conf_num_visible;
    conf_done = 1;
    clr_hs();
    while (cyc < 4000) begin
      if (rd_request && wr_request) both_req = 1;
      if (done) begin got_done = 1; break; end
      if (fresh && train_start) begin
        e.kind = 2'd2; e.idx = '0; e.len = '0; got_q.push_back(e); tr_cnt = $urandom % 3;
      end
      if (fresh && predict_start) begin
        e.kind = 2'd3; e.idx = '0; e.len = '0; got_q.push_back(e); pr_cnt = $urandom % 3;
      end
      if (init_done) begin
        conf_num_movies = $urandom; conf_num_users = $urandom; conf_num_loops = $urandom;
        conf_num_testusers = $urandom; conf_num_hidden = $urandom; conf_num_visible = $urandom;
      end
      clr_hs();
      st = ($urandom % 4) != 0;
      step = st;
      if (st) begin
        if (rd_cnt >= 0) begin
          if (rd_cnt == 0) rd_complete = 1;
          rd_cnt--;
        end else if (rd_request && ($urandom % 2 == 1)) begin
          rd_grant = 1;
          e.kind = 2'd0; e.idx = rd_index; e.len = rd_length; got_q.push_back(e);
          if ($urandom % 3 == 0) rd_complete = 1; else rd_cnt = $urandom % 3;
        end
        if (wr_cnt >= 0) begin
          if (wr_cnt == 0) wr_complete = 1;
          wr_cnt--;
        end else if (wr_request && ($urandom % 2 == 1)) begin
          wr_grant = 1;
          e.kind = 2'd1; e.idx = wr_index; e.len = wr_length; got_q.push_back(e);
          if ($urandom % 3 == 0) wr_complete = 1; else wr_cnt = $urandom % 3;
        end
        if (tr_cnt >= 0) begin
          if (tr_cnt == 0) train_done = 1;
          tr_cnt--;
        end
        if (pr_cnt >= 0) begin
          if (pr_cnt == 0) predict_done = 1;
          pr_cnt--;
        end
        // Stray strobes that can never coincide with their waiting state.
        if (tst == 0) begin
          if ($urandom % 5 == 0) predict_done = 1;
          if ($urandom % 5 == 0) wr_complete = 1;
        end
        if (!(lps != 0 && usr != 0) && ($urandom % 5 == 0)) train_done = 1;
      end
      fresh = st;
      tick();
      cyc++;
    end
    clr_hs();
    chk({name, "_reached_done"}, 64'(got_done), 64'd1);
    chk({name, "_req_overlap"}, 64'(both_req), 64'd0);
    chk({name, "_event_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_ev%0d_kind", name, i), 64'(got_q[i].kind), 64'(exp_q[i].kind));
      chk($sformatf("%s_ev%0d_idx", name, i), 64'(got_q[i].idx), 64'(exp_q[i].idx));
      chk($sformatf("%s_ev%0d_len", name, i), 64'(got_q[i].len), 64'(exp_q[i].len));
    end
    chk({name, "_upc_done"}, 64'(upc), 64'd7);
    chk({name, "_init_done"}, 64'(init_done), 64'd1);
    chk({name, "_num_movies"}, 64'(num_movies), 64'(16'(mov)));
    chk({name, "_num_users"}, 64'(num_users), 64'(16'(usr)));
    chk({name, "_num_loops"}, 64'(num_loops), 64'(16'(lps)));
    chk({name, "_num_testusers"}, 64'(num_testusers), 64'(16'(tst)));
    chk({name, "_num_hidden"}, 64'(num_hidden), 64'(hid[15:0]));
    chk({name, "_num_visible"}, 64'(num_visible), 64'(vis[15:0]));
    chk({name, "_loop_count"}, 64'(loop_count), 64'((lps != 0 && usr != 0) ? 16'(lps) : 16'd0));
    chk({name, "_user_index"}, 64'(user_index), 64'(16'(tst)));
    step = 1;
    tick();
    chk({name, "_done_held"}, 64'(done), 64'd1);
    conf_done = 0;
    tick();
    chk({name, "_back_idle"}, 64'(upc), 64'd0);
    chk({name, "_done_clr"}, 64'(done), 64'd0);
    chk({name, "_init_clr"}, 64'(init_done), 64'd0);
    step = 0;
  endtask

  initial begin
    rst = 0; step = 0; conf_done = 0;
    set_conf(0, 0, 0, 0);
    clr_hs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_upc", 64'(upc), 64'd0);
    chk("rst_requests", 64'({rd_request, wr_request, train_start, predict_start}), 64'd0);
    chk("rst_flags", 64'({init_done, done}), 64'd0);
    chk("rst_dma", 64'({rd_index, rd_length}), 64'd0);
    chk("rst_cfg", 64'({num_movies, num_users, loop_count, user_index}), 64'd0);
    rst = 1;

    // Loops=0 with users: straight to DONE, and nothing latches while step is low.
    set_conf(7, 5, 0, 0);
    conf_done = 1;
    step = 0;
    tick();
    chk("nostep_upc", 64'(upc), 64'd0);
    chk("nostep_init", 64'(init_done), 64'd0);
    step = 1;
    tick();
    chk("noloop_upc", 64'(upc), 64'd7);
    chk("noloop_done", 64'(done), 64'd1);
    chk("noloop_reqs", 64'({rd_request, wr_request}), 64'd0);
    conf_done = 0;
    tick();
    chk("noloop_idle", 64'(upc), 64'd0);

    // Grant and complete in the same step skip RD_WAIT.
    set_conf(2, 1, 1, 0);
    conf_done = 1;
    tick();
    chk("skip_rdreq", 64'(upc), 64'd1);
    chk("skip_rdlen", 64'(rd_length), 64'd10);
    chk("skip_rdreqhi", 64'(rd_request), 64'd1);
    rd_grant = 1; rd_complete = 1;
    tick();
    clr_hs();
    chk("skip_train", 64'(upc), 64'd3);
    chk("skip_tstart", 64'(train_start), 64'd1);
    tick();
    chk("skip_tstart_pulse", 64'(train_start), 64'd0);
    train_done = 1;
    tick();
    clr_hs();
    chk("skip_done", 64'(upc), 64'd7);
    chk("skip_loops", 64'(loop_count), 64'd1);
    conf_done = 0;
    tick();

    // RD_WAIT frozen while step is low even with rd_complete high.
    set_conf(2, 0, 0, 1);
    conf_done = 1;
    tick();
    rd_grant = 1;
    tick();
    rd_grant = 0;
    chk("hold_rdwait", 64'(upc), 64'd2);
    step = 0; rd_complete = 1;
    repeat (10) tick();
    chk("hold_upc", 64'(upc), 64'd2);
    chk("hold_pstart", 64'(predict_start), 64'd0);
    step = 1;
    tick();
    rd_complete = 0;
    chk("hold_predict", 64'(upc), 64'd4);
    chk("hold_pstart_hi", 64'(predict_start), 64'd1);
    predict_done = 1;
    tick();
    predict_done = 0;
    chk("wr_req_upc", 64'(upc), 64'd5);
    chk("wr_req_len", 64'({wr_request, wr_length}), {32'd1, 32'd10});
    chk("wr_req_idx", 64'(wr_index), 64'd0);
    wr_grant = 1;
    tick();
    wr_grant = 0;
    chk("wr_wait_upc", 64'(upc), 64'd6);

    // Asynchronous reset in WR_WAIT, effective before any clock edge.
    #2 rst = 0;
    #1;
    chk("arst_upc", 64'(upc), 64'd0);
    chk("arst_wrreq", 64'(wr_request), 64'd0);
    chk("arst_done", 64'({done, init_done}), 64'd0);
    chk("arst_wrlen", 64'({wr_index, wr_length}), 64'd0);
    #1 rst = 1;
    step = 0;
    tick();
    chk("arst_nostep", 64'(upc), 64'd0);
    conf_done = 0; step = 1;
    tick();
    chk("arst_noresume", 64'({upc, rd_request, wr_request}), 64'd0);
    step = 0;

    run_scenario("train2", 4, 2, 1, 0);
    run_scenario("pred2", 3, 0, 1, 2);
    for (int i = 0; i < 6; i++)
      run_scenario($sformatf("rand%0d", i), $urandom_range(1, 400), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rbm_compute_seq.md
RBM_COMPUTE_SEQ -- requirements
Module: rbm_compute_seq

Interface
REQ-001 Parameter IDX_W, default 16, width of latched configuration counts and counters.
REQ-002 Parameter ADDR_W, default 32, width of DMA index/length fields.
REQ-003 Parameter K_RATINGS, default 5, rating levels per movie; DMA length = K_RATINGS*num_movies.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 step  in  1  advance enable; no state or output change when low, except reset.
REQ-007 conf_done  in  1  configuration valid.
REQ-008 conf_num_movies, conf_num_users, conf_num_testusers, conf_num_loops, conf_num_hidden, conf_num_visible  in  32 each  configuration values.
REQ-009 rd_grant, rd_complete  in  1 each  read DMA handshake.
REQ-010 wr_grant, wr_complete  in  1 each  write DMA handshake.
REQ-011 train_done, predict_done  in  1 each  compute engine finished current user.
REQ-012 rd_request  out  1; rd_index, rd_length  out  ADDR_W each  read DMA command.
REQ-013 wr_request  out  1; wr_index, wr_length  out  ADDR_W each  write DMA command.
REQ-014 train_start, predict_start  out  1 each  one-step pulse to compute engine.
REQ-015 num_movies, num_users, num_testusers, num_loops, num_hidden, num_visible  out  IDX_W each  latched configuration.
REQ-016 loop_count, user_index  out  IDX_W each  progress counters.
REQ-017 upc  out  4  state code; init_done, done  out  1 each.

Function
REQ-018 States/upc: IDLE=0, RD_REQ=1, RD_WAIT=2, TRAIN=3, PREDICT=4, WR_REQ=5, WR_WAIT=6, DONE=7; codes 8-15 unused, treated as IDLE.
REQ-019 IDLE: on step & conf_done, latch conf_* truncated to low IDX_W bits, set init_done=1, clear loop_count, user_index, select phase.
REQ-020 Phase select: training if num_loops!=0 & num_users!=0 -> RD_REQ; else prediction if num_testusers!=0 -> RD_REQ; else -> DONE.
REQ-021 rd_length = K_RATINGS*num_movies zero-extended to ADDR_W, modulo 2^ADDR_W; rd_index = user_index*rd_length modulo 2^ADDR_W; both updated on entry to RD_REQ.
REQ-022 RD_REQ: rd_request=1, held until rd_grant sampled high; then rd_request=0 -> RD_WAIT.
REQ-023 rd_grant & rd_complete high in same RD_REQ step: skip RD_WAIT, go directly to TRAIN/PREDICT.
REQ-024 RD_WAIT: on rd_complete -> TRAIN (training phase) or PREDICT (prediction phase), asserting train_start or predict_start for exactly that one step.
REQ-025 TRAIN: on train_done, user_index+1; if user_index==num_users-1 then user_index=0, loop_count+1; if loop_count then equals num_loops, enter prediction phase per REQ-020 prediction rule; else -> RD_REQ.
REQ-026 PREDICT: on predict_done -> WR_REQ; wr_length = rd_length, wr_index = user_index*wr_length modulo 2^ADDR_W.
REQ-027 WR_REQ/WR_WAIT: same rules as REQ-022..023 with wr_* signals; on wr_complete user_index+1; if prior user_index==num_testusers-1 -> DONE, else -> RD_REQ.
REQ-028 DONE: done=1, held; returns to IDLE with done=0, init_done=0 only when conf_done sampled low.
REQ-029 rd_complete/wr_complete/train_done/predict_done outside their waiting state: ignored, no effect.
REQ-030 Counters wrap at 2^IDX_W; no saturation.
REQ-031 rd_request and wr_request never both high.
REQ-032 conf_* changes after latch have no effect until next IDLE.

Reset
REQ-033 rst low asynchronously forces upc=IDLE; all 1-bit outputs 0; all counters, config latches, rd_index, rd_length, wr_index, wr_length = 0.
REQ-034 rst low mid-transfer drops rd_request/wr_request immediately; no resumption after release.
REQ-035 First state change after rst rises requires a clk edge with step=1.

Verification
REQ-036 movies=4, users=2, loops=1, testusers=0: reads index 0 then 20, length 20, two train_start pulses, done=1, no wr_request.
REQ-037 movies=3, users=0, testusers=2: read/write pairs at index 0 and 15, length 15, done after second wr_complete.
REQ-038 rd_grant and rd_complete same step -> upc RD_REQ->TRAIN in one step, train_start=1.
REQ-039 step held low 10 cycles in RD_WAIT with rd_complete high -> upc stays 2; advances on first step-high edge.
REQ-040 rst low during WR_WAIT -> wr_request=0, upc=0, done=0 before next clk edge.
REQ-041 loops=0, users=5, testusers=0 -> IDLE->DONE in one step, no requests.
